// File: rtl/rr_arb4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb4_pkg
// Brief   : Shared arbiter definitions: FSM encodings, select width, source
//           count and a select-to-onehot helper used with the 4:1 mux.
// Revision: 1.0 - initial release
// ============================================================================
package rr_arb4_pkg;

    localparam int c_num_src = 4;
    localparam int c_sel_w   = 2;
    localparam int c_cnt_w   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [c_num_src-1:0] sel_to_onehot(input logic [c_sel_w-1:0] sel);
        logic [c_num_src-1:0] w_oh;
        w_oh      = '0;
        w_oh[sel] = 1'b1;
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Rotating-priority search: first set req bit from last+1 upward
//           (mod 4). Purely combinational.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_arb4_pkg::*;
(
    input  logic [c_num_src-1:0] req,
    input  logic [c_sel_w-1:0]   last,
    output logic [c_sel_w-1:0]   idx,
    output logic                 any
);

    logic [c_sel_w-1:0] w_cand;

    // Walk from the farthest candidate (last itself) back to last+1 so the
    // nearest requester overwrites earlier hits and wins.
    always_comb begin
        idx    = last;
        any    = 1'b0;
        w_cand = '0;
        for (int k = c_num_src; k >= 1; k--) begin
            w_cand = last + c_sel_w'(k);
            if (req[w_cand]) begin
                idx = w_cand;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb4
// Brief   : 4-source round-robin arbiter with registered select/grant/valid
//           for a downstream 4:1 mux. Optional hold limit: RR_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_num_src-1:0] req,
    output logic [c_sel_w-1:0]   s,
    output logic [c_num_src-1:0] gnt,
    output logic                 v
);

    arb_state_t           r_state;
    logic [c_sel_w-1:0]   r_last;
    logic [c_sel_w-1:0]   r_s;
    logic [c_num_src-1:0] r_gnt;
    logic                 r_v;
    logic [c_sel_w-1:0]   w_idx;
    logic                 w_any;
    logic                 w_expire;

    rr_pick u_pick (
        .req  (req),
        .last (r_last),
        .idx  (w_idx),
        .any  (w_any)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    logic [c_cnt_w-1:0] r_cnt;
    assign w_expire = (r_cnt == c_cnt_last);
`else
    logic [c_cnt_w-1:0] w_unused_timeout;
    assign w_unused_timeout = c_cnt_w'(TIMEOUT);
    assign w_expire         = 1'b0;
`endif

    // The owner is r_s itself; releasing records it as last so the next
    // search starts just past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 2'b11;
            r_s     <= '0;
            r_gnt   <= '0;
            r_v     <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_s     <= w_idx;
                        r_gnt   <= sel_to_onehot(w_idx);
                        r_v     <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[r_s] || w_expire) begin
                        r_state <= IDLE;
                        r_v     <= 1'b0;
                        r_gnt   <= '0;
                        r_last  <= r_s;
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        r_cnt   <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_v     <= 1'b0;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign s   = r_s;
    assign gnt = r_gnt;
    assign v   = r_v;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arb4
// Brief   : Self-checking bench for rr_arb4: directed scenarios plus random
//           requests against a behavioural round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arb4;

    localparam int TIMEOUT = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit c_to_en = 1'b1;
`else
    localparam bit c_to_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       v;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    rr_arb4 #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .s   (s),
        .gnt (gnt),
        .v   (v)
    );

    // Reference model: owner held while its request stays high (and under
    // the hold limit); otherwise one idle cycle then the nearest requester
    // after the previous owner wins.
    bit         m_busy  = 1'b0;
    int         m_owner = 0;
    int         m_last  = 3;
    int         m_cnt   = 0;
    logic [1:0] m_s     = 2'd0;

    always @(posedge clk or posedge rst) begin : model
        int j;
        bit expire;
        if (rst) begin
            m_busy = 1'b0;
            m_last = 3;
            m_s    = 2'd0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                j = (m_last + k) % 4;
                if (!m_busy && req[j]) begin
                    m_busy  = 1'b1;
                    m_owner = j;
                    m_s     = j[1:0];
                    m_cnt   = 0;
                end
            end
        end else begin
            expire = c_to_en && (m_cnt == TIMEOUT - 1);
            if (!req[m_owner] || expire) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin : onehot_mon
        logic [3:0] exp_g;
        if (mon_en && !rst) begin
            exp_g = v ? (4'b0001 << s) : 4'b0000;
            n_checks++;
            if (gnt !== exp_g || $countones(gnt) > 1) begin
                $display("FAIL onehot: gnt=%b v=%b s=%0d, required gnt=%b", gnt, v, s, exp_g);
                n_errors++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== 7'b0) begin
            $display("FAIL reset_outputs: v,s,gnt=%b, required %b", {v, s, gnt}, 7'b0);
            n_errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== 7'b0) begin
            $display("FAIL idle_no_req: v,s,gnt=%b, required %b", {v, s, gnt}, 7'b0);
            n_errors++;
        end
    endtask

    task automatic test_basic();
        req = 4'b0101;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b1, 2'd0, 4'b0001}) begin
            $display("FAIL basic_first: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd0, 4'b0001});
            n_errors++;
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({v, s, gnt} !== {1'b1, 2'd0, 4'b0001}) begin
                $display("FAIL basic_hold: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd0, 4'b0001});
                n_errors++;
            end
        end
        req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b0, 2'd0, 4'b0000}) begin
            $display("FAIL basic_release: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b0, 2'd0, 4'b0000});
            n_errors++;
        end
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b1, 2'd2, 4'b0100}) begin
            $display("FAIL basic_next: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd2, 4'b0100});
            n_errors++;
        end
        req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b0, 2'd2, 4'b0000}) begin
            $display("FAIL basic_s_hold: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b0, 2'd2, 4'b0000});
            n_errors++;
        end
    endtask

    task automatic test_wrap();
        req = 4'b1011;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b1, 2'd3, 4'b1000}) begin
            $display("FAIL wrap_grant: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd3, 4'b1000});
            n_errors++;
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_regrant();
        for (int i = 0; i < 4; i++) begin
            req = 4'b0010;
            @(negedge clk);
            n_checks++;
            if ({v, s, gnt} !== {1'b1, 2'd1, 4'b0010}) begin
                $display("FAIL regrant_%0d: v,s,gnt=%b, required %b", i, {v, s, gnt}, {1'b1, 2'd1, 4'b0010});
                n_errors++;
            end
            req = 4'b0000;
            @(negedge clk);
            n_checks++;
            if ({v, s, gnt} !== {1'b0, 2'd1, 4'b0000}) begin
                $display("FAIL regrant_idle_%0d: v,s,gnt=%b, required %b", i, {v, s, gnt}, {1'b0, 2'd1, 4'b0000});
                n_errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b1, 2'd2, 4'b0100}) begin
            $display("FAIL async_pre: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd2, 4'b0100});
            n_errors++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        n_checks++;
        if ({v, s, gnt} !== 7'b0) begin
            $display("FAIL async_drop: v,s,gnt=%b, required %b", {v, s, gnt}, 7'b0);
            n_errors++;
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        n_checks++;
        if ({v, s, gnt} !== {1'b1, 2'd0, 4'b0001}) begin
            $display("FAIL async_search0: v,s,gnt=%b, required %b", {v, s, gnt}, {1'b1, 2'd0, 4'b0001});
            n_errors++;
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

`ifdef RR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [6:0] exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i < 4)       exp = {1'b1, 2'd0, 4'b0001};
            else if (i == 4) exp = {1'b0, 2'd0, 4'b0000};
            else if (i < 9)  exp = {1'b1, 2'd1, 4'b0010};
            else if (i == 9) exp = {1'b0, 2'd1, 4'b0000};
            else             exp = {1'b1, 2'd0, 4'b0001};
            n_checks++;
            if ({v, s, gnt} !== exp) begin
                $display("FAIL timeout_cyc%0d: v,s,gnt=%b, required %b", i, {v, s, gnt}, exp);
                n_errors++;
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask
`else
    task automatic test_hold();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if ({v, s, gnt} !== {1'b1, 2'd0, 4'b0001}) begin
                $display("FAIL hold_cyc%0d: v,s,gnt=%b, required %b", i, {v, s, gnt}, {1'b1, 2'd0, 4'b0001});
                n_errors++;
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic [3:0] exp_g;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            exp_g = m_busy ? (4'b0001 << m_s) : 4'b0000;
            n_checks++;
            if ({v, s, gnt} !== {m_busy, m_s, exp_g}) begin
                $display("FAIL random_cyc%0d: v,s,gnt=%b, required %b (req=%b)", i, {v, s, gnt}, {m_busy, m_s, exp_g}, req);
                n_errors++;
            end
            if ($urandom_range(0, 3) == 0)
                req = 4'($urandom_range(0, 15));
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_wrap();
        test_regrant();
        test_async_reset();
`ifdef RR_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
